// File: rtl/jericalla_sequencer.sv
// jericalla_sequencer: plays a loaded 16-entry program onto the Jericalla 17-bit control bus
// ports: clk/rst (sync, active high); prog_we/prog_addr/prog_data write the program in IDLE;
//        prog_len/stop_on_zero are latched on start; abort kills a run; zflg is the datapath zero flag;
//        bus/pc/busy/done/halted_zero are all registered outputs
module jericalla_sequencer #(
   parameter int HOLD_CYCLES = 2,
   parameter bit GATE_RW     = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        prog_we,
   input  logic [3:0]  prog_addr,
   input  logic [16:0] prog_data,
   input  logic [4:0]  prog_len,
   input  logic        start,
   input  logic        abort,
   input  logic        stop_on_zero,
   input  logic        zflg,
   output logic [16:0] bus,
   output logic [3:0]  pc,
   output logic        busy,
   output logic        done,
   output logic        halted_zero
);
   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
   state_t state, state_n;
   logic [16:0] mem [16];
   logic [16:0] bus_n, w_n, ld_n;
   logic [4:0]  len, len_n;
   logic [3:0]  cnt, cnt_n, pc_n;
   logic        soz, soz_n, busy_n, done_n, hz_n, last_pc;
   // a write in the same cycle as start at address 0 must be the first word issued
   assign w_n = (state == IDLE) ? ((prog_we && prog_addr == 4'd0) ? prog_data : mem[0]) : mem[pc + 4'd1];
   // RW only rises in the final hold cycle when gating, so a single-cycle window shows it at once
   assign ld_n = {w_n[16:1], (!GATE_RW || HOLD_CYCLES == 1) ? w_n[0] : 1'b0};
   assign last_pc = {1'b0, pc} == len - 5'd1;
   always_ff @(posedge clk) if (state == IDLE && prog_we) mem[prog_addr] <= prog_data;
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         bus         <= '0;
         pc          <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         halted_zero <= 1'b0;
         cnt         <= '0;
         len         <= '0;
         soz         <= 1'b0;
      end else begin
         state       <= state_n;
         bus         <= bus_n;
         pc          <= pc_n;
         busy        <= busy_n;
         done        <= done_n;
         halted_zero <= hz_n;
         cnt         <= cnt_n;
         len         <= len_n;
         soz         <= soz_n;
      end
   end
   always_comb begin
      state_n = state;
      bus_n   = bus;
      pc_n    = pc;
      busy_n  = busy;
      hz_n    = halted_zero;
      cnt_n   = cnt;
      len_n   = len;
      soz_n   = soz;
      case (state)
         IDLE: if (start) begin
            hz_n  = 1'b0;
            len_n = prog_len;
            soz_n = stop_on_zero;
            if (prog_len == 5'd0) state_n = FINISH;
            else begin
               state_n = RUN;
               pc_n    = '0;
               bus_n   = ld_n;
               busy_n  = 1'b1;
               cnt_n   = 4'(HOLD_CYCLES - 1);
            end
         end
         RUN: if (abort) begin
            state_n = IDLE;
            bus_n   = '0;
            busy_n  = 1'b0;
         end else if (cnt != 4'd0) begin
            cnt_n = cnt - 4'd1;
            bus_n = {bus[16:1], (!GATE_RW || cnt == 4'd1) ? mem[pc][0] : 1'b0};
         end else if ((soz && zflg) || last_pc) begin
            state_n = FINISH;
            hz_n    = soz && zflg;
            bus_n   = '0;
            busy_n  = 1'b0;
         end else begin
            pc_n  = pc + 4'd1;
            bus_n = ld_n;
            cnt_n = 4'(HOLD_CYCLES - 1);
         end
         default: state_n = IDLE;
      endcase
      done_n = state_n == FINISH;
   end
endmodule
